// File: rtl/al422_pkg.sv
// Shared definitions for the AL422 frame FIFO write path and the reader.
// The frame byte format constants must stay in step with al422_bam_bs.
package al422_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_RST  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FULL = 3'd4
  } wr_state_e;

  localparam int AL422_CAPACITY = 393216;
  localparam int BYTE_CNT_W     = 19;

  // Header byte at the start of each frame, as decoded by al422_bam_bs.
  localparam int HDR_PLANE_LSB = 0;
  localparam int HDR_PLANE_MSB = 2;
  localparam int HDR_GAMMA_BIT = 6;
  localparam int HDR_VALID_BIT = 7;

  // Number of in_clk cycles spent in the write-reset sequence (two per WCK period).
  function automatic int unsigned rst_ticks(input int unsigned periods);
    return (periods < 1) ? 2 : 2 * periods;
  endfunction

endpackage

// File: rtl/al422_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module al422_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/al422_wr_ctrl.sv
// AL422 write-side controller: frames an upstream byte stream into the FIFO,
// issuing /WRST at every frame start and clocking bytes with /WE and WCK.
module al422_wr_ctrl
  import al422_pkg::*;
#(
  parameter int FRAME_BYTES    = AL422_CAPACITY,
  parameter int WRST_CYCLES    = 4,
  parameter bit LOCK_TO_READER = 1'b1
) (
  input  logic                  in_clk,
  input  logic                  in_nrst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  input  logic                  rd_rewind_n,
  output logic [7:0]            al422_d_out,
  output logic                  al422_wck_out,
  output logic                  al422_we_out,
  output logic                  al422_wrst_out,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [BYTE_CNT_W-1:0] byte_cnt
);

  localparam int RST_TICKS = int'(rst_ticks(WRST_CYCLES));
  localparam int RC_W      = (RST_TICKS > 2) ? $clog2(RST_TICKS) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_TICKS - 1);
  localparam logic [BYTE_CNT_W-1:0] CNT_MAX = BYTE_CNT_W'(FRAME_BYTES);

  wr_state_e             state_q, state_d;
  logic                  ph_q, ph_d;
  logic [7:0]            skid_q, skid_d;
  logic [RC_W-1:0]       rc_q, rc_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  rdy_q, rdy_d;
  logic                  wck_q, wck_d;
  logic                  we_q, we_d;
  logic                  wrst_q, wrst_d;
  logic [7:0]            dat_q, dat_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  sync_first_q, sync_first_d;
  logic                  rew_prev_q;
  logic                  rew_s;
  logic                  take;
  logic                  begin_frame;
  logic                  start_rst;
  logic                  rew_fall;

  al422_sync2 #(
    .RST_VAL(1'b1)
  ) u_rew_sync (
    .clk_i (in_clk),
    .rst_ni(in_nrst),
    .d_i   (rd_rewind_n),
    .q_o   (rew_s)
  );

  assign take = in_valid & rdy_q;
  // A rewind already in progress when SYNC is entered counts as the edge.
  assign rew_fall = ~rew_s & (sync_first_q | rew_prev_q);

  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    skid_d       = skid_q;
    rc_d         = rc_q;
    cnt_d        = cnt_q;
    rdy_d        = rdy_q;
    wck_d        = wck_q;
    we_d         = we_q;
    wrst_d       = wrst_q;
    dat_d        = dat_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    sync_first_d = 1'b0;
    begin_frame  = 1'b0;
    start_rst    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rdy_d = 1'b1;
        we_d  = 1'b1;
        wck_d = 1'b0;
        ph_d  = 1'b0;
        if (take && in_sof) begin
          begin_frame = 1'b1;
        end
      end

      ST_SYNC: begin
        rdy_d = 1'b0;
        we_d  = 1'b1;
        wck_d = 1'b0;
        if (rew_fall) begin
          start_rst = 1'b1;
        end
      end

      ST_RST: begin
        if (rc_q == RC_LAST) begin
          // Leave reset with the setup half of the skid byte already done.
          state_d = ST_RUN;
          wrst_d  = 1'b1;
          dat_d   = skid_q;
          we_d    = 1'b0;
          wck_d   = 1'b0;
          ph_d    = 1'b1;
          rdy_d   = 1'b0;
        end else begin
          rc_d  = rc_q + RC_W'(1);
          wck_d = ~wck_q;
        end
      end

      ST_RUN: begin
        if (ph_q) begin
          wck_d = 1'b1;
          ph_d  = 1'b0;
          rdy_d = 1'b1;
          cnt_d = cnt_q + BYTE_CNT_W'(1);
          if (cnt_q + BYTE_CNT_W'(1) == CNT_MAX) begin
            state_d = ST_FULL;
            done_d  = 1'b1;
          end
        end else begin
          wck_d = 1'b0;
          if (take) begin
            if (in_sof) begin
              done_d      = 1'b1;
              begin_frame = 1'b1;
            end else begin
              dat_d = in_data;
              we_d  = 1'b0;
              ph_d  = 1'b1;
              rdy_d = 1'b0;
            end
          end else begin
            we_d = 1'b1;
          end
        end
      end

      ST_FULL: begin
        rdy_d = 1'b1;
        we_d  = 1'b1;
        wck_d = 1'b0;
        if (take) begin
          if (in_sof) begin
            begin_frame = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (begin_frame) begin
      skid_d = in_data;
      cnt_d  = '0;
      ovf_d  = 1'b0;
      rdy_d  = 1'b0;
      we_d   = 1'b1;
      wck_d  = 1'b0;
      ph_d   = 1'b0;
      if (LOCK_TO_READER) begin
        state_d      = ST_SYNC;
        sync_first_d = 1'b1;
      end else begin
        start_rst = 1'b1;
      end
    end

    if (start_rst) begin
      state_d = ST_RST;
      rc_d    = '0;
      wrst_d  = 1'b0;
      we_d    = 1'b1;
      wck_d   = 1'b0;
      rdy_d   = 1'b0;
    end
  end

  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q      <= ST_IDLE;
      ph_q         <= 1'b0;
      skid_q       <= '0;
      rc_q         <= '0;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
      wck_q        <= 1'b0;
      we_q         <= 1'b1;
      wrst_q       <= 1'b1;
      dat_q        <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      sync_first_q <= 1'b0;
      rew_prev_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      skid_q       <= skid_d;
      rc_q         <= rc_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      wck_q        <= wck_d;
      we_q         <= we_d;
      wrst_q       <= wrst_d;
      dat_q        <= dat_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      sync_first_q <= sync_first_d;
      rew_prev_q   <= rew_s;
    end
  end

  assign in_ready       = rdy_q;
  assign al422_d_out    = dat_q;
  assign al422_wck_out  = wck_q;
  assign al422_we_out   = we_q;
  assign al422_wrst_out = wrst_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;
  assign byte_cnt       = cnt_q;

endmodule

// File: tb/tb_al422_wr_ctrl.sv
// Bench for al422_wr_ctrl: one free-running instance (A) and one locked to the
// reader rewind (B), both with 16-byte frames, checked against a frame model.
module tb_al422_wr_ctrl;

  localparam int FB = 16;
  localparam int WR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_nrst, a_valid, a_sof, a_rdy, a_rew, a_wck, a_we, a_wrst, a_fd, a_ovf;
  logic [7:0]  a_din, a_d;
  logic [18:0] a_cnt;
  logic        b_nrst, b_valid, b_sof, b_rdy, b_rew, b_wck, b_we, b_wrst, b_fd, b_ovf;
  logic [7:0]  b_din, b_d;
  logic [18:0] b_cnt;

  al422_wr_ctrl #(.FRAME_BYTES(FB), .WRST_CYCLES(WR), .LOCK_TO_READER(1'b0)) dut_a (
    .in_clk(clk), .in_nrst(a_nrst), .in_data(a_din), .in_valid(a_valid), .in_sof(a_sof),
    .in_ready(a_rdy), .rd_rewind_n(a_rew), .al422_d_out(a_d), .al422_wck_out(a_wck),
    .al422_we_out(a_we), .al422_wrst_out(a_wrst), .frame_done(a_fd), .overflow(a_ovf),
    .byte_cnt(a_cnt)
  );

  al422_wr_ctrl #(.FRAME_BYTES(FB), .WRST_CYCLES(WR), .LOCK_TO_READER(1'b1)) dut_b (
    .in_clk(clk), .in_nrst(b_nrst), .in_data(b_din), .in_valid(b_valid), .in_sof(b_sof),
    .in_ready(b_rdy), .rd_rewind_n(b_rew), .al422_d_out(b_d), .al422_wck_out(b_wck),
    .al422_we_out(b_we), .al422_wrst_out(b_wrst), .frame_done(b_fd), .overflow(b_ovf),
    .byte_cnt(b_cnt)
  );

  // FIFO-side observation: bytes captured, write-reset WCK periods, frame_done pulses.
  logic [7:0] a_wq[$];
  logic [7:0] b_wq[$];
  int a_rst_n = 0, b_rst_n = 0, a_fd_n = 0, b_fd_n = 0;

  always @(posedge a_wck) begin
    if (a_wrst === 1'b0) a_rst_n++;
    else if (a_we === 1'b0) a_wq.push_back(a_d);
  end
  always @(posedge b_wck) begin
    if (b_wrst === 1'b0) b_rst_n++;
    else if (b_we === 1'b0) b_wq.push_back(b_d);
  end
  always @(posedge clk) begin
    if (a_fd === 1'b1) a_fd_n++;
    if (b_fd === 1'b1) b_fd_n++;
  end

  // Frame-level reference model.
  logic [7:0] a_exp[$];
  logic [7:0] b_exp[$];
  bit m_in[2];
  int m_fl[2];
  bit m_ovf[2];
  int m_fd[2];
  int m_rst[2];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_add(input int k, input logic [7:0] d);
    if (k == 0) a_exp.push_back(d);
    else b_exp.push_back(d);
  endtask

  task automatic model(input int k, input logic [7:0] d, input logic s);
    if (s) begin
      if (m_in[k] && m_fl[k] < FB) m_fd[k]++;
      m_in[k]  = 1'b1;
      m_fl[k]  = 1;
      m_ovf[k] = 1'b0;
      m_rst[k] += WR;
      model_add(k, d);
    end else if (m_in[k]) begin
      if (m_fl[k] < FB) begin
        m_fl[k]++;
        model_add(k, d);
        if (m_fl[k] == FB) m_fd[k]++;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic s, input bit upd);
    bit ok;
    ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
    end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (k == 0) begin
        a_valid = 1'b1; a_din = d; a_sof = s; ok = a_rdy;
      end else begin
        b_valid = 1'b1; b_din = d; b_sof = s; ok = b_rdy;
      end
      if (ok) @(posedge clk);
    end
    chk($sformatf("accept%0d", k), 32'(ok), 32'd1);
    if (upd && ok) model(k, d, s);
  endtask

  task automatic idle(input int k, input int n);
    @(negedge clk);
    if (k == 0) a_valid = 1'b0; else b_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic verify(input int k, input string tag);
    int exp_cnt;
    exp_cnt = m_in[k] ? m_fl[k] : 0;
    if (k == 0) begin
      chk({tag, " nwr"}, a_wq.size(), a_exp.size());
      for (int i = 0; i < a_exp.size(); i++)
        if (i < a_wq.size()) chk($sformatf("%s wr[%0d]", tag, i), a_wq[i], a_exp[i]);
      chk({tag, " wrst_periods"}, a_rst_n, m_rst[0]);
      chk({tag, " frame_done"}, a_fd_n, m_fd[0]);
      chk({tag, " overflow"}, a_ovf, m_ovf[0]);
      chk({tag, " byte_cnt"}, a_cnt, exp_cnt);
    end else begin
      chk({tag, " nwr"}, b_wq.size(), b_exp.size());
      for (int i = 0; i < b_exp.size(); i++)
        if (i < b_wq.size()) chk($sformatf("%s wr[%0d]", tag, i), b_wq[i], b_exp[i]);
      chk({tag, " wrst_periods"}, b_rst_n, m_rst[1]);
      chk({tag, " frame_done"}, b_fd_n, m_fd[1]);
      chk({tag, " overflow"}, b_ovf, m_ovf[1]);
      chk({tag, " byte_cnt"}, b_cnt, exp_cnt);
    end
  endtask

  logic [7:0] t1 [12];
  logic [7:0] r;
  bit hit;

  initial begin
    t1 = '{8'h2F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h44};
    a_nrst = 1'b0; a_valid = 1'b0; a_sof = 1'b0; a_din = '0; a_rew = 1'b1;
    b_nrst = 1'b0; b_valid = 1'b0; b_sof = 1'b0; b_din = '0; b_rew = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 1'b0; m_fl[k] = 0; m_ovf[k] = 1'b0; m_fd[k] = 0; m_rst[k] = 0;
    end

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst in_ready", a_rdy, 0);
    chk("rst wck", a_wck, 0);
    chk("rst we", a_we, 1);
    chk("rst wrst", a_wrst, 1);
    chk("rst d", a_d, 0);
    chk("rst frame_done", a_fd, 0);
    chk("rst overflow", a_ovf, 0);
    chk("rst byte_cnt", a_cnt, 0);
    chk("rst b we", b_we, 1);
    a_nrst = 1'b1;
    b_nrst = 1'b1;
    repeat (3) @(negedge clk);

    // Bytes without SOF after reset are accepted and dropped
    for (int i = 0; i < 10; i++) push(0, 8'($urandom), 1'b0, 1'b1);
    idle(0, 4);
    chk("nosof we", a_we, 1);
    verify(0, "nosof");

    // SOF + 11 bytes, immediate write reset
    push(0, t1[0], 1'b1, 1'b1);
    for (int i = 1; i < 12; i++) push(0, t1[i], 1'b0, 1'b1);
    idle(0, 6);
    verify(0, "t1");

    // SOF in the middle of a frame restarts the frame
    r = 8'($urandom);
    push(0, r, 1'b1, 1'b1);
    #1;
    chk("sof1 frame_done", a_fd, 1);
    chk("sof1 byte_cnt", a_cnt, 0);
    for (int i = 0; i < 4; i++) push(0, 8'($urandom), 1'b0, 1'b1);
    r = 8'($urandom);
    push(0, r, 1'b1, 1'b1);
    #1;
    chk("sof5 frame_done", a_fd, 1);
    chk("sof5 byte_cnt", a_cnt, 0);
    chk("sof5 wrst", a_wrst, 0);
    for (int i = 0; i < 3; i++) push(0, 8'($urandom), 1'b0, 1'b1);
    idle(0, 14);
    verify(0, "midsof");

    // Frame limit: SOF + 20 bytes, only 16 written, then recovery on next SOF
    push(0, 8'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) push(0, 8'($urandom), 1'b0, 1'b1);
    idle(0, 6);
    verify(0, "full");
    push(0, 8'($urandom), 1'b1, 1'b1);
    #1;
    chk("full sof overflow", a_ovf, 0);
    chk("full sof wrst", a_wrst, 0);
    idle(0, 14);
    verify(0, "after_full");

    // Reader lock: nothing happens until the rewind falls
    push(1, 8'($urandom), 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      b_valid = 1'b0;
      chk("sync ready", b_rdy, 0);
      chk("sync wrst", b_wrst, 1);
    end
    b_rew = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 4 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = (b_wrst === 1'b0);
    end
    chk("wrst within 4", 32'(hit), 1);
    @(negedge clk);
    b_rew = 1'b1;
    for (int i = 0; i < 3; i++) push(1, 8'($urandom), 1'b0, 1'b1);
    idle(1, 6);
    verify(1, "lock");

    // Asynchronous reset in the middle of a write
    push(0, 8'($urandom), 1'b0, 1'b0);
    #1;
    chk("pre-reset we", a_we, 0);
    a_nrst = 1'b0;
    #1;
    chk("arst we", a_we, 1);
    chk("arst wrst", a_wrst, 1);
    chk("arst wck", a_wck, 0);
    chk("arst ready", a_rdy, 0);
    chk("arst byte_cnt", a_cnt, 0);
    chk("arst d", a_d, 0);
    m_in[0] = 1'b0; m_fl[0] = 0; m_ovf[0] = 1'b0;
    @(negedge clk);
    a_valid = 1'b0;
    a_nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("idle ready", a_rdy, 1);
    idle(0, 4);
    verify(0, "arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
